icache_param: RTL and testbench

ICACHE_PARAM -- requirements
Module: icache_param

---
 rtl/icache_pkg.sv | 18 +
 rtl/icache_line_store.sv | 55 +++++
 rtl/icache_param.sv | 146 ++++++++++++++
 tb/tb_icache_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped, read-only instruction cache.
// Holds the refill FSM state encoding and the default geometry constants
// used by icache_param and icache_line_store.
package icache_pkg;

    typedef enum logic [1:0] {
        st_idle,
        st_refill,
        st_commit
    } state_t;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_WORD_W     = 32;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_NUM_LINES  = 16;
    localparam int unsigned MISS_CNT_W     = 16;

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the instruction cache: data, tag and valid arrays.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (valid bits only)
//   rd_index             lookup index; rd_line/rd_tag/rd_valid read asynchronously
//   wr_en, wr_index,     synchronous line write, also sets the valid bit
//   wr_tag, wr_line
//   clear                clears every valid bit at the next edge (wins over wr_en)
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned TAG_W     = 24,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned NUM_LINES = DEF_NUM_LINES,
    localparam int unsigned IDX_W    = $clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [LINE_W-1:0] rd_line,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic              clear
);

    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    // Data and tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index] <= wr_line;
            tag_q[wr_index]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    assign rd_line  = data_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/icache_param.sv
// Direct-mapped, read-only instruction cache with single-line refill.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cpu_req, address      fetch request and byte address (bits [1:0] ignored)
//   flush                 single-cycle invalidate-all pulse
//   instruction, hit      fetched word, valid in the cycle hit=1 (combinational)
//   stall                 CPU must hold address/cpu_req
//   mem_req, mem_addr     line refill request, line-aligned address
//   mem_ready, dataline   refill completion and line data (word 0 in LSBs)
//   miss_count            saturating count of refills started
module icache_param
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    localparam int unsigned LINE_W    = WORD_W * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  flush,
    output logic [WORD_W-1:0]     instruction,
    output logic                  hit,
    output logic                  stall,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ready,
    input  logic [LINE_W-1:0]     dataline,
    output logic [MISS_CNT_W-1:0] miss_count
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    state_t state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;
    logic [TAG_W-1:0] fill_tag_q;
    logic [IDX_W-1:0] fill_idx_q;

    logic [OFF_W-1:0]  addr_off;
    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [LINE_W-1:0] rd_line;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              lookup_hit;
    logic              miss_start;
    logic              fill_en;
    logic              clear_all;

    assign addr_off = address[OFF_W+1:2];
    assign addr_idx = address[OFF_W+2 +: IDX_W];
    assign addr_tag = address[ADDR_W-1 -: TAG_W];

    assign lookup_hit = cpu_req & rd_valid & (rd_tag == addr_tag) & ~flush;
    assign miss_start = (state_q == st_idle) & cpu_req & ~lookup_hit & ~flush;
    assign fill_en    = (state_q == st_refill) & mem_ready;
    // A flush seen during REFILL/COMMIT is applied on the COMMIT->IDLE edge so
    // the line just filled is dropped too.
    assign clear_all  = ((state_q == st_idle) & flush) |
                        ((state_q == st_commit) & (flush_pend_q | flush));

    icache_line_store #(
        .TAG_W     (TAG_W),
        .LINE_W    (LINE_W),
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (addr_idx),
        .rd_line  (rd_line),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (fill_en),
        .wr_index (fill_idx_q),
        .wr_tag   (fill_tag_q),
        .wr_line  (dataline),
        .clear    (clear_all)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= st_idle;
            flush_pend_q <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (miss_start) begin
            fill_tag_q <= addr_tag;
            fill_idx_q <= addr_idx;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        miss_count_d = miss_count_q;
        unique case (state_q)
            st_idle: begin
                if (miss_start) begin
                    state_d = st_refill;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + 1'b1;
                    end
                end
            end
            st_refill: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d = st_commit;
                end
            end
            st_commit: begin
                flush_pend_d = 1'b0;
                state_d      = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    // Outputs
    always_comb begin
        hit         = (state_q == st_idle) & lookup_hit;
        stall       = (cpu_req & ~hit) | (state_q != st_idle);
        mem_req     = (state_q == st_refill);
        mem_addr    = {fill_tag_q, fill_idx_q, {(OFF_W + 2){1'b0}}};
        instruction = rd_line[addr_off * WORD_W +: WORD_W];
        miss_count  = miss_count_q;
    end

endmodule

// File: tb/tb_icache_param.sv
module tb_icache_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic [31:0]  address;
    logic         flush;
    logic [31:0]  instruction;
    logic         hit;
    logic         stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] dataline;
    logic [15:0]  miss_count;

    int checks   = 0;
    int failures = 0;

    icache_param dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .address     (address),
        .flush       (flush),
        .instruction (instruction),
        .hit         (hit),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .dataline    (dataline),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge in REFILL: deliver line, pass COMMIT, land in IDLE.
    task automatic refill(input logic [127:0] line);
        mem_ready = 1'b1;
        dataline  = line;
        @(negedge clk);
        mem_ready = 1'b0;
        dataline  = '0;
        check("commit_mem_req", mem_req, 1'b0);
        check("commit_hit", hit, 1'b0);
        check("commit_stall", stall, 1'b1);
        @(negedge clk);
    endtask

    localparam logic [127:0] LINE_A = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h10101010};
    localparam logic [127:0] LINE_B = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'h40404040};

    initial begin
        rst = 1'b1; cpu_req = 1'b1; address = 32'h40; flush = 1'b0;
        mem_ready = 1'b0; dataline = '0;
        @(negedge clk);
        check("rst_hit", hit, 1'b0);
        check("rst_stall", stall, 1'b1);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_miss_count", miss_count, 16'd0);

        // First miss on 0x40
        rst = 1'b0;
        #1;
        check("miss0_hit", hit, 1'b0);
        check("miss0_stall", stall, 1'b1);
        @(negedge clk);
        check("refill0_mem_req", mem_req, 1'b1);
        check("refill0_mem_addr", mem_addr, 32'h40);
        check("refill0_miss_count", miss_count, 16'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("refill0_hold_req", mem_req, 1'b1);
            check("refill0_hold_addr", mem_addr, 32'h40);
        end
        address = 32'h48;
        refill(LINE_A);
        check("fill0_hit", hit, 1'b1);
        check("fill0_stall", stall, 1'b0);
        check("fill0_word2", instruction, 32'hDEADBEEF);
        address = 32'h40; #1;
        check("fill0_word0", instruction, 32'h10101010);
        address = 32'h4C; #1;
        check("fill0_word3", instruction, 32'h33333333);

        // Stray mem_ready in IDLE must not write
        address = 32'h48; mem_ready = 1'b1; dataline = {4{32'h0BAD0BAD}};
        @(negedge clk);
        mem_ready = 1'b0; dataline = '0; #1;
        check("stray_ready_hit", hit, 1'b1);
        check("stray_ready_word", instruction, 32'hDEADBEEF);
        check("stray_ready_count", miss_count, 16'd1);

        // Conflict miss on 0x140 (same index 4)
        address = 32'h140; #1;
        check("conf_hit", hit, 1'b0);
        @(negedge clk);
        check("conf_mem_addr", mem_addr, 32'h140);
        check("conf_count", miss_count, 16'd2);
        refill(LINE_B);
        check("conf_fill_hit", hit, 1'b1);
        check("conf_fill_word", instruction, 32'hA0A0A0A0);
        address = 32'h40; #1;
        check("evicted_hit", hit, 1'b0);
        @(negedge clk);
        check("evicted_count", miss_count, 16'd3);
        check("evicted_mem_addr", mem_addr, 32'h40);
        refill(LINE_C);
        check("refetch_hit", hit, 1'b1);
        check("refetch_word", instruction, 32'h40404040);

        // Flush in IDLE
        flush = 1'b1; #1;
        check("flush_idle_hit", hit, 1'b0);
        check("flush_idle_stall", stall, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_no_refill", mem_req, 1'b0);
        check("flush_idle_count", miss_count, 16'd3);
        #1;
        check("flush_idle_after_hit", hit, 1'b0);
        @(negedge clk);
        check("flush_refill_count", miss_count, 16'd4);

        // Flush during REFILL: fill completes, then line dropped
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_pend_mem_req", mem_req, 1'b1);
        refill(LINE_C);
        check("flush_pend_hit", hit, 1'b0);
        check("flush_pend_stall", stall, 1'b1);
        @(negedge clk);
        check("flush_pend_count", miss_count, 16'd5);
        refill(LINE_C);
        check("flush_pend_refill_hit", hit, 1'b1);

        // Reset two cycles into REFILL
        address = 32'h140;
        @(negedge clk);
        check("rst_mid_count", miss_count, 16'd6);
        check("rst_mid_req", mem_req, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; #1;
        check("rst_mid_mem_req", mem_req, 1'b0);
        check("rst_mid_count0", miss_count, 16'd0);
        check("rst_mid_stall", stall, 1'b1);
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0; mem_ready = 1'b1; dataline = LINE_B;
        @(negedge clk);
        check("rst_mid_idle_req", mem_req, 1'b0);
        mem_ready = 1'b0; dataline = '0; cpu_req = 1'b1; #1;
        check("rst_mid_miss140", hit, 1'b0);
        address = 32'h40; #1;
        check("rst_mid_miss40", hit, 1'b0);
        address = 32'h140;
        @(negedge clk);
        check("rst_mid_refill_count", miss_count, 16'd1);
        check("rst_mid_refill_addr", mem_addr, 32'h140);
        refill(LINE_B);
        check("rst_mid_fill_word", instruction, 32'hA0A0A0A0);

        // Saturation
        cpu_req = 1'b0;
        force dut.miss_count_d = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.miss_count_d;
        @(negedge clk);
        check("sat_preset", miss_count, 16'hFFFE);
        cpu_req = 1'b1; address = 32'h240;
        @(negedge clk);
        check("sat_ffff", miss_count, 16'hFFFF);
        refill(LINE_A);
        address = 32'h340; #1;
        check("sat_miss_hit", hit, 1'b0);
        @(negedge clk);
        check("sat_hold", miss_count, 16'hFFFF);
        check("sat_mem_addr", mem_addr, 32'h340);
        refill(LINE_A);
        check("sat_final_word", instruction, 32'h10101010);
        check("sat_final_count", miss_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
